// File: rtl/serial_frame_rx.sv
`timescale 1ns / 1ps
// Oversampling receiver for the injector's serial link: synchronizes ser_clk/ser_data, samples on
// the synchronized falling edge and deserializes LSB-first frames into a one-entry output register.
module serial_frame_rx #(
  parameter int unsigned FRAME_BITS   = 24,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned IDLE_TIMEOUT = 256,
  localparam int unsigned CntW        = $clog2(FRAME_BITS + 1),
  localparam int unsigned IdleW       = $clog2(IDLE_TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ser_clk,
  input  logic                  ser_data,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  frame_err,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [CntW-1:0]       bit_cnt
);

  typedef enum logic {StIdle, StRecv} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [IdleW-1:0]       idle_q, idle_d;
  logic [FRAME_BITS-1:0]  frame_data_q, frame_data_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overflow_q, overflow_d;

  logic                  clk_s, data_s, sample, push, ovf_set;
  logic [FRAME_BITS-1:0] shifted;

  always_comb begin
    // Both lines share the same synchronizer depth so data stays aligned with its clock.
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ser_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ser_data};
    clk_s       = clk_sync_q[SYNC_STAGES-1];
    data_s      = data_sync_q[SYNC_STAGES-1];
    clk_prev_d  = clk_s;
    sample      = clk_prev_q & ~clk_s;
    shifted     = {data_s, shift_q[FRAME_BITS-1:1]};

    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    idle_d      = idle_q;
    frame_err_d = 1'b0;
    push        = 1'b0;

    unique case (state_q)
      StIdle: begin
        idle_d = '0;
        if (sample) begin
          shift_d   = shifted;
          bit_cnt_d = CntW'(1);
          state_d   = StRecv;
        end
      end
      StRecv: begin
        if (sample) begin
          idle_d  = '0;
          shift_d = shifted;
          if (bit_cnt_q == CntW'(FRAME_BITS - 1)) begin
            push      = 1'b1;
            bit_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end else if (idle_q == IdleW'(IDLE_TIMEOUT - 1)) begin
          // Link went quiet mid-frame: drop the partial word.
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          shift_d     = '0;
          idle_d      = '0;
          state_d     = StIdle;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
      end
    endcase

    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    ovf_set       = 1'b0;
    if (push) begin
      if (!frame_valid_q || frame_ready) begin
        frame_data_d  = shifted;
        frame_valid_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end
    overflow_d = ovf_set | (overflow_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      clk_sync_q    <= '0;
      data_sync_q   <= '0;
      clk_prev_q    <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      idle_q        <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_sync_q    <= clk_sync_d;
      data_sync_q   <= data_sync_d;
      clk_prev_q    <= clk_prev_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      idle_q        <= idle_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;
  assign bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
`timescale 1ns / 1ps
// Bench for serial_frame_rx: drives a slow serial link and checks received words, error pulses
// and flags against a frame-level reference model.
module tb_serial_frame_rx;
  localparam int unsigned FB   = 24;
  localparam int unsigned SS   = 2;
  localparam int unsigned TO   = 256;
  localparam int          HALF = 500;

  logic          clk = 1'b0, reset = 1'b0;
  logic          ser_clk = 1'b0, ser_data = 1'b0;
  logic          frame_ready = 1'b0, ovf_clr = 1'b0;
  logic [FB-1:0] frame_data;
  logic          frame_valid, frame_err, overflow;
  logic [4:0]    bit_cnt;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, fall_cyc = 0, err_cnt = 0, err_cyc = -1;
  logic [FB-1:0] got_q[$];
  logic [FB-1:0] exp_q[$];

  serial_frame_rx #(
    .FRAME_BITS  (FB),
    .SYNC_STAGES (SS),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ser_clk    (ser_clk),
    .ser_data   (ser_data),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after posedge, so at negedge valid&&ready is the handshake of the next edge.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_valid && frame_ready) got_q.push_back(frame_data);
      if (frame_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got_q.size()) return {8'h0, got_q[i]};
    return 'x;
  endfunction

  task automatic ser_rise(input logic b);
    @(negedge clk);
    #2 ser_clk = 1'b1;
    #1 ser_data = b;
    #(HALF - 1);
  endtask

  task automatic ser_fall();
    ser_clk  = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic send_bit(input logic b);
    ser_rise(b);
    ser_fall();
    #(HALF - 10);
  endtask

  task automatic send_frame(input logic [FB-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(w[i]);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 frame_ready = v;
  endtask

  task automatic wait_cyc(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, cycles 0x%0h", cyc);
    $fatal(1);
  end

  initial begin
    logic [FB-1:0] w;
    int            n, exp_err;

    // Reset state
    repeat (4) @(negedge clk);
    check_eq("rst_data", frame_data, 0);
    check_eq("rst_valid", frame_valid, 0);
    check_eq("rst_err", frame_err, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_cnt", bit_cnt, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(negedge clk);

    // Basic frame with consumer always ready
    set_ready(1'b1);
    got_q.delete();
    err_cnt = 0;
    send_frame(24'hA1B2C3, FB);
    repeat (10) @(negedge clk);
    check_eq("basic_n", got_q.size(), 1);
    check_eq("basic_data", got_at(0), 32'hA1B2C3);
    check_eq("basic_ovf", overflow, 0);
    check_eq("basic_err", err_cnt, 0);
    check_eq("basic_valid", frame_valid, 0);

    // Back-to-back frames into a full output register
    set_ready(1'b0);
    got_q.delete();
    send_frame(24'hA1B2C3, FB);
    send_frame(24'h5A5A5A, FB);
    send_frame(24'hFFFFFF, FB);
    repeat (10) @(negedge clk);
    check_eq("b2b_held", frame_data, 32'hA1B2C3);
    check_eq("b2b_valid", frame_valid, 1);
    check_eq("b2b_ovf", overflow, 1);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    set_ready(1'b0);
    @(negedge clk);
    check_eq("b2b_n", got_q.size(), 1);
    check_eq("b2b_data", got_at(0), 32'hA1B2C3);
    check_eq("b2b_ovf_kept", overflow, 1);
    @(posedge clk);
    #1 ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    @(negedge clk);
    check_eq("ovf_clr", overflow, 0);

    // Synchronizer latency on the first bit, then a 10-bit partial frame that times out
    set_ready(1'b1);
    got_q.delete();
    err_cnt = 0;
    ser_rise(1'b1);
    ser_fall();
    wait_cyc(fall_cyc + SS);
    check_eq("sync_lat_early", bit_cnt, 0);
    @(negedge clk);
    check_eq("sync_lat", bit_cnt, 1);
    repeat (20) @(negedge clk);
    send_frame(24'h2B5, 9);
    repeat (300) @(negedge clk);
    check_eq("to_err_n", err_cnt, 1);
    check_eq("to_err_cyc", err_cyc, fall_cyc + SS + 1 + TO);
    check_eq("to_cnt", bit_cnt, 0);
    check_eq("to_no_frame", got_q.size(), 0);
    send_frame(24'h000001, FB);
    repeat (10) @(negedge clk);
    check_eq("to_next_n", got_q.size(), 1);
    check_eq("to_next_data", got_at(0), 32'h000001);

    // Completion of a new frame in the same cycle the held frame is accepted
    set_ready(1'b0);
    got_q.delete();
    send_frame(24'hABCDEF, FB);
    w = 24'h123456;
    send_frame(w, FB - 1);
    ser_rise(w[FB-1]);
    ser_fall();
    do begin
      @(posedge clk);
      #1;
    end while (cyc < fall_cyc + SS);
    frame_ready = 1'b1;
    @(posedge clk);
    #1 frame_ready = 1'b0;
    @(negedge clk);
    check_eq("sim_data", frame_data, 32'h123456);
    check_eq("sim_valid", frame_valid, 1);
    check_eq("sim_ovf", overflow, 0);
    check_eq("sim_old", got_at(0), 32'hABCDEF);
    #(HALF - 60);
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    check_eq("sim_new", got_at(1), 32'h123456);

    // Asynchronous reset in the middle of a frame while a frame is held
    set_ready(1'b0);
    send_frame(24'h3C3C3C, FB);
    send_frame(24'hFFFFFF, 12);
    check_eq("pre_rst_cnt", bit_cnt, 12);
    #3 reset = 1'b0;
    #1;
    check_eq("mid_rst_data", frame_data, 0);
    check_eq("mid_rst_valid", frame_valid, 0);
    check_eq("mid_rst_cnt", bit_cnt, 0);
    check_eq("mid_rst_ovf", overflow, 0);
    check_eq("mid_rst_err", frame_err, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (400) @(negedge clk);
    set_ready(1'b1);
    got_q.delete();
    send_frame(24'hC34DA1, FB);
    repeat (10) @(negedge clk);
    check_eq("post_rst_n", got_q.size(), 1);
    check_eq("post_rst_data", got_at(0), 32'hC34DA1);

    // Random full and partial frames against the frame-level model
    got_q.delete();
    exp_q.delete();
    err_cnt = 0;
    exp_err = 0;
    for (int it = 0; it < 12; it++) begin
      w = FB'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(1, FB - 1);
        send_frame(w, n);
        repeat (300) @(negedge clk);
        exp_err++;
      end else begin
        send_frame(w, FB);
        exp_q.push_back(w);
        repeat ($urandom_range(0, 40)) @(negedge clk);
      end
    end
    repeat (20) @(negedge clk);
    check_eq("rnd_n", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check_eq("rnd_data", got_at(i), {8'h0, exp_q[i]});
    check_eq("rnd_err", err_cnt, exp_err);
    check_eq("rnd_ovf", overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
